imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream over a valid/ready link and assembles little-endian 32-bit words.
- Writes each word into the CPU instruction memory write port.
- Holds the pipelined CPU in reset until the last program word, at byte address MAX_INST_ADDR, is written.
- Replaces simulation-only preloading of instruction memory, so programs can be loaded in-system.

Parameters:
- IMEM_DEPTH, 1024, instruction memory size in 32-bit words.
- MAX_INST_ADDR, 32'h2c, byte address of the last program instruction; word aligned; must be < IMEM_DEPTH*4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  32  byte address of the write, word aligned.
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  reset to the CPU; high except in DONE.
- busy  output  1  high in RECV or WRITE.
- done  output  1  high in DONE.
- err  output  1  sticky; start was seen while MAX_INST_ADDR >= IMEM_DEPTH*4.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. No other reset.
- Values after rst: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0. Byte index and word buffer are cleared.
- States: IDLE, RECV, WRITE, DONE. All outputs are registered or decoded from state only; in_ready does not depend combinationally on in_valid.
- IDLE:
  - in_ready=0, cpu_rst=1.
  - start=1 with a legal MAX_INST_ADDR: go to RECV, imem_addr<=0, byte index<=0.
  - start=1 with an illegal MAX_INST_ADDR: set err=1 and stay in IDLE.
- RECV:
  - in_ready=1.
  - A byte transfers when in_valid && in_ready. Byte n (n=0..3) goes into buffer bits [8n+7:8n] (little-endian), then n increments.
  - On the transfer of byte 3, go to WRITE.
  - in_valid low: hold state, buffer and index.
- WRITE:
  - Exactly one cycle. imem_we=1, imem_wdata=buffer, imem_addr=current address, in_ready=0.
  - Next state: DONE if imem_addr==MAX_INST_ADDR. Otherwise imem_addr<=imem_addr+4, index<=0, go to RECV.
- DONE:
  - done=1, cpu_rst=0, in_ready=0, imem_we=0.
  - start=1: reload. Go to RECV, imem_addr<=0, cpu_rst=1 from the next cycle.
- start in RECV or WRITE is ignored.
- imem_we is never high outside WRITE. Exactly (MAX_INST_ADDR/4)+1 writes occur per load.
- Timing, with start in cycle 0 and in_valid held high:
  - Bytes transfer in cycles 5k+1..5k+4.
  - Word k is written in cycle 5k+5.
  - Default parameters: last write (k=11) in cycle 60; done=1 and cpu_rst=0 from cycle 61.
- rst mid-load: return to IDLE the next cycle, discard the partial word, no write issued, cpu_rst=1. A byte presented in the rst cycle is not accepted.
- rst has priority over start in the same cycle.
- Address arithmetic is 32-bit with no wrap, guaranteed by the MAX_INST_ADDR check.

Test Plan:
- Reset: rst high 1 cycle, then 5 idle cycles -> cpu_rst=1, in_ready=0, imem_we=0, done=0 throughout.
- Full load, default parameters: start, then stream bytes 0x00..0x2f continuously -> 12 writes at 0x00..0x2c. Word0=0x03020100, word11=0x2f2e2d2c. done and cpu_rst=0 at cycle 61. The CPU runs the loaded program.
- Backpressure and gaps: in_valid toggled 1,0,0,1 pattern during the load -> same memory contents as the full load, each write exactly 1 cycle, no duplicate or missing bytes.
- Reset mid-word: after 2 bytes of word 3, assert rst -> no write to 0x0c, state IDLE. A new start plus a full stream reloads everything correctly.
- Reload from DONE: start -> cpu_rst=1 on the next cycle, imem_addr=0, new contents overwrite the old ones. start pulses during RECV are ignored (write count stays 12).
- Illegal parameter: MAX_INST_ADDR=32'h1000 with IMEM_DEPTH=1024, start -> err=1, stays in IDLE, no writes.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the CPU instruction memory.
// Bytes arrive over a valid/ready link and are packed into little-endian
// 32-bit words. Each finished word is written for one cycle, and the CPU is
// held in reset until the word at MAX_INST_ADDR has been written.
module imem_loader #(
  parameter int unsigned IMEM_DEPTH    = 1024,
  parameter logic [31:0] MAX_INST_ADDR = 32'h2c
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  // The range check is done in 64 bits so a large IMEM_DEPTH cannot overflow it.
  localparam logic [63:0] IMEM_BYTES = 64'(IMEM_DEPTH) * 64'd4;
  localparam bit          ADDR_LEGAL = ({32'd0, MAX_INST_ADDR} < IMEM_BYTES);

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_buf;
  logic [31:0] r_addr;
  logic        r_err;

  // Load sequencing: byte packing, word address stepping and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (ADDR_LEGAL) begin
              r_state <= S_RECV;
              r_addr  <= '0;
              r_idx   <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (in_valid) begin
            r_buf[{r_idx, 3'b000} +: 8] <= in_data;
            r_idx                       <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (r_addr == MAX_INST_ADDR) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 32'd4;
            r_idx   <= '0;
            r_state <= S_RECV;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state <= S_RECV;
            r_addr  <= '0;
            r_idx   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs are decoded from the registered state only,
  // so in_ready never depends combinationally on in_valid.
  always_comb begin
    in_ready   = (r_state == S_RECV);
    imem_we    = (r_state == S_WRITE);
    busy       = (r_state == S_RECV) || (r_state == S_WRITE);
    done       = (r_state == S_DONE);
    cpu_rst    = (r_state != S_DONE);
    imem_addr  = r_addr;
    imem_wdata = r_buf;
    err        = r_err;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, full load timing, gapped stream,
// reload from DONE with ignored start pulses, reset mid-word, reset/start
// priority and an illegal MAX_INST_ADDR instance.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, imem_we, cpu_rst, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;

  logic        b_start = 1'b0;
  logic        b_in_ready, b_we, b_cpu_rst, b_busy, b_done, b_err;
  logic [31:0] b_addr, b_wdata;

  always #5 clk = ~clk;

  imem_loader #(.IMEM_DEPTH(1024), .MAX_INST_ADDR(32'h2c)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  imem_loader #(.IMEM_DEPTH(1024), .MAX_INST_ADDR(32'h1000)) u_bad (
    .clk(clk), .rst(rst), .start(b_start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .cpu_rst(b_cpu_rst), .busy(b_busy), .done(b_done), .err(b_err)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc;
  int          bptr;
  int          wr_cnt;
  int          first_wr_cyc;
  int          last_wr_cyc;
  bit          prev_we;
  logic [31:0] mem [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] base, input int k);
    logic [7:0] b0;
    b0 = base + 8'(4 * k);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  // One clock: note a transfer committed by this edge, then log any write.
  task automatic step();
    bit xfer;
    xfer = in_valid && in_ready && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (xfer) bptr++;
    if (imem_we) begin
      wr_cnt++;
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      mem[imem_addr[11:2]] = imem_wdata;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    prev_we = imem_we;
  endtask

  // Start a load in cycle 0, then stream bytes base+n until DONE, max_bytes
  // transferred, or the cycle budget runs out.
  task automatic load(input logic [7:0] base, input bit gaps, input int max_bytes,
                      input int glitch_cyc);
    logic [3:0] pat;
    pat = 4'b1001;
    cyc = 0; bptr = 0; wr_cnt = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    start = 1'b1;
    in_valid = 1'b0;
    step();
    start = 1'b0;
    check("post_start_state", {28'd0, in_ready, cpu_rst, busy, done}, 32'b1110);
    check("post_start_addr", imem_addr, 32'h0);
    while (!done && bptr < max_bytes && cyc < 400) begin
      in_valid = gaps ? pat[cyc % 4] : 1'b1;
      in_data  = base + 8'(bptr);
      start    = (cyc == glitch_cyc);
      step();
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (cyc >= 400) check("load_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic check_contents(input string tag, input logic [7:0] base);
    for (int k = 0; k < 12; k++) check(tag, mem[k], word_of(base, k));
    check("write_count", 32'(wr_cnt), 32'd12);
    check("done_outputs", {27'd0, in_ready, imem_we, cpu_rst, busy, done}, 32'b00001);
    check("final_addr", imem_addr, 32'h2c);
  endtask

  initial begin
    cyc = 0; bptr = 0; wr_cnt = 0; prev_we = 1'b0;
    first_wr_cyc = -1; last_wr_cyc = -1;

    // Reset, then idle
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_outputs", {26'd0, cpu_rst, in_ready, imem_we, done, busy, err}, 32'b100000);
    end
    check("idle_addr", imem_addr, 32'h0);
    check("idle_wdata", imem_wdata, 32'h0);
    check("idle_bad_err", {31'd0, b_err}, 32'd0);

    // Full continuous load: word k written in cycle 5k+5, DONE from 61
    load(8'h00, 1'b0, 1000, -1);
    check("first_write_cycle", 32'(first_wr_cyc), 32'd5);
    check("last_write_cycle", 32'(last_wr_cyc), 32'd60);
    check("done_cycle", 32'(cyc), 32'd61);
    check_contents("full_word", 8'h00);
    check("no_err", {31'd0, err}, 32'd0);

    // Reload from DONE with a gapped stream and a stray start mid-load
    load(8'h40, 1'b1, 1000, 20);
    check_contents("gap_word", 8'h40);

    // Reset after two bytes of word 3
    load(8'h80, 1'b0, 14, -1);
    check("pre_rst_writes", 32'(wr_cnt), 32'd3);
    check("pre_rst_addr", imem_addr, 32'h0c);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    step();
    rst = 1'b0;
    check("rst_mid_state", {27'd0, in_ready, imem_we, cpu_rst, busy, done}, 32'b00100);
    check("rst_mid_addr", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) step();
    in_valid = 1'b0;
    check("rst_mid_no_write", 32'(wr_cnt), 32'd3);
    check("rst_mid_idle", {27'd0, in_ready, imem_we, cpu_rst, busy, done}, 32'b00100);
    load(8'hc0, 1'b0, 1000, -1);
    check("reload_done_cycle", 32'(cyc), 32'd61);
    check_contents("reload_word", 8'hc0);

    // rst wins over start from DONE
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check("rst_over_start", {28'd0, in_ready, cpu_rst, busy, done}, 32'b0100);
    step();
    check("rst_over_start_hold", {28'd0, in_ready, cpu_rst, busy, done}, 32'b0100);

    // Illegal MAX_INST_ADDR instance: err set, stays idle, never writes
    b_start = 1'b1;
    in_valid = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bad_flags", {26'd0, b_we, b_in_ready, b_busy, b_done, b_cpu_rst, b_err},
            32'b000011);
      check("bad_addr_data", b_addr | b_wdata, 32'h0);
      step();
    end
    in_valid = 1'b0;
    check("bad_err_sticky", {31'd0, b_err}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
